// File: rtl/watch_pkg.sv
// Shared definitions for the watch: field widths, wrap limits, one-hot digit
// select codes and the single-field wrap helper used by the datapath.
package watch_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  localparam logic [2:0] DIGIT_SEL_SEC  = 3'b001;
  localparam logic [2:0] DIGIT_SEL_MIN  = 3'b010;
  localparam logic [2:0] DIGIT_SEL_HOUR = 3'b100;

  // One step up or down inside [0, max], wrapping at both ends.
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) return (val == max) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/watch_dp_tick_gen.sv
// 1 Hz prescaler: free-running counter 0..TICK_DIV-1 with a one-cycle
// sec_tick while the counter sits at its last value.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sec_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/watch_dp.sv
// Time-keeping datapath: hh:mm:ss registers advanced by the prescaler tick,
// with per-field up/down adjustment that defers a colliding tick by one flag.
module watch_dp
  import watch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_digit_pos,
  input  logic              i_up,
  input  logic              i_down,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  logic sec_tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick)
  );

  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;

  logic pos_legal;
  logic adj_valid;
  logic tick_req;
  logic [5:0] hour_step;

  always_comb begin
    pos_legal = (i_digit_pos == DIGIT_SEL_SEC) ||
                (i_digit_pos == DIGIT_SEL_MIN) ||
                (i_digit_pos == DIGIT_SEL_HOUR);
    adj_valid = (i_up ^ i_down) && pos_legal;
    tick_req  = sec_tick | pend_q;
  end

  // An adjustment always wins the cycle; a tick arriving alongside it is
  // parked in pend_q and applied in the next adjustment-free cycle.
  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    pend_d    = 1'b0;
    tick_d    = 1'b0;
    hour_step = '0;
    if (adj_valid) begin
      pend_d = tick_req;
      case (i_digit_pos)
        DIGIT_SEL_SEC:  sec_d = wrap_step(sec_q, SEC_MAX, i_up);
        DIGIT_SEL_MIN:  min_d = wrap_step(min_q, MIN_MAX, i_up);
        DIGIT_SEL_HOUR: begin
          hour_step = wrap_step({1'b0, hour_q}, {1'b0, HOUR_MAX}, i_up);
          hour_d    = hour_step[HOUR_W-1:0];
        end
        default: ;
      endcase
    end else if (tick_req) begin
      tick_d = 1'b1;
      sec_d  = wrap_step(sec_q, SEC_MAX, 1'b1);
      if (sec_q == SEC_MAX) begin
        min_d = wrap_step(min_q, MIN_MAX, 1'b1);
        if (min_q == MIN_MAX) begin
          hour_step = wrap_step({1'b0, hour_q}, {1'b0, HOUR_MAX}, 1'b1);
          hour_d    = hour_step[HOUR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
    end
  end

  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hour_q;
  assign o_tick = tick_q;

endmodule
